// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem addressing and the IF/ID register with decode handshake.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module fetch_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_DEPTH   = 256,
    parameter int          HALT_ON_ZERO = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_inst,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic        fetch_err,
    output logic        misalign_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {BOOT, FETCH, HALT} state_t;

    localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        fetch_err_q, fetch_err_d;
    logic        misalign_err_q, misalign_err_d;

    logic        advance;
    logic        out_of_range;
    logic        capture;
    logic [31:0] redir_pc;
    logic        redir_mis;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        id_valid_d     = id_valid_q;
        id_inst_d      = id_inst_q;
        id_pc_d        = id_pc_q;
        fetch_err_d    = fetch_err_q;
        misalign_err_d = 1'b0;
        capture        = 1'b0;

        advance      = !id_valid_q || id_ready;
        out_of_range = ({2'b00, pc_q[31:2]} >= DEPTH_W);
        redir_pc     = {redirect_pc[31:2], 2'b00};
        redir_mis    = |redirect_pc[1:0];

        case (state_q)
            BOOT: begin
                state_d = FETCH;
                if (redirect_valid) begin
                    pc_d           = redir_pc;
                    misalign_err_d = redir_mis;
                end
            end
            FETCH: begin
                // Redirect wins over stall, halt and range checks: the word at the old pc is dead.
                if (redirect_valid) begin
                    pc_d           = redir_pc;
                    id_valid_d     = 1'b0;
                    misalign_err_d = redir_mis;
                end else if (out_of_range) begin
                    fetch_err_d = 1'b1;
                    state_d     = HALT;
                    if (advance) id_valid_d = 1'b0;
                end else if (advance && (HALT_ON_ZERO != 0) && (imem_inst == 32'h0)) begin
                    id_valid_d = 1'b0;
                    state_d    = HALT;
                end else if (advance) begin
                    capture = 1'b1;
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    pc_d           = redir_pc;
                    id_valid_d     = 1'b0;
                    misalign_err_d = redir_mis;
                    fetch_err_d    = 1'b0;
                    state_d        = FETCH;
                end else if (id_valid_q && id_ready) begin
                    // Drain the last entry; nothing new is fetched while halted.
                    id_valid_d = 1'b0;
                end
            end
            default: state_d = BOOT;
        endcase

        if (capture) begin
            id_inst_d  = imem_inst;
            id_pc_d    = pc_q;
            id_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= BOOT;
            pc_q           <= RESET_PC;
            id_valid_q     <= 1'b0;
            id_inst_q      <= 32'h0;
            id_pc_q        <= 32'h0;
            fetch_err_q    <= 1'b0;
            misalign_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            id_valid_q     <= id_valid_d;
            id_inst_q      <= id_inst_d;
            id_pc_q        <= id_pc_d;
            fetch_err_q    <= fetch_err_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    assign imem_pc      = pc_q;
    assign id_valid     = id_valid_q;
    assign id_inst      = id_inst_q;
    assign id_pc        = id_pc_q;
    assign halted       = (state_q == HALT);
    assign fetch_err    = fetch_err_q;
    assign misalign_err = misalign_err_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (capture) fetch_cnt_d = fetch_cnt_q + 32'd1;
        if ((state_q == FETCH) && id_valid_q && !id_ready && !redirect_valid)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a vector table walks the main scenarios, then
// hand-written sequences cover halt-while-stalled and redirect during BOOT.
module tb_fetch_stage;

    localparam logic [31:0] IA = 32'h002081B3;
    localparam logic [31:0] IB = 32'h404182B3;
    localparam logic [31:0] IC = 32'h00532023;
    localparam logic [31:0] ID = 32'h00032383;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_pc;
    logic [31:0] imem_inst;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;
    logic        fetch_err;
    logic        misalign_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    logic [31:0] mem [256];

    int checks = 0;
    int failures = 0;

    fetch_stage #(.RESET_PC(32'h0), .IMEM_DEPTH(256), .HALT_ON_ZERO(1)) dut (
        .clk(clk), .rst(rst),
        .imem_pc(imem_pc), .imem_inst(imem_inst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_inst(id_inst), .id_pc(id_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halted(halted), .fetch_err(fetch_err), .misalign_err(misalign_err)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Out-of-range rows return a nonzero pattern so only the range check can halt there.
    assign imem_inst = (imem_pc[31:10] == 22'h0) ? mem[imem_pc[9:2]] : 32'hDEAD_BEEF;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] e_pc;
        logic        e_v;
        logic [31:0] e_inst;
        logic [31:0] e_idpc;
        logic        e_halt;
        logic        e_ferr;
        logic        e_mis;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic rdy, logic rv, logic [31:0] rpc,
                                logic [31:0] pc, logic v, logic [31:0] inst, logic [31:0] idpc,
                                logic h, logic f, logic m);
        vec_t t;
        t.rst = r; t.rdy = rdy; t.rv = rv; t.rpc = rpc;
        t.e_pc = pc; t.e_v = v; t.e_inst = inst; t.e_idpc = idpc;
        t.e_halt = h; t.e_ferr = f; t.e_mis = m;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_step(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
        rst = r; id_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc, input logic v,
                           input logic [31:0] inst, input logic [31:0] idpc,
                           input logic h, input logic f, input logic m);
        chk({tag, ".pc"},       imem_pc, pc);
        chk({tag, ".id_valid"}, {31'h0, id_valid}, {31'h0, v});
        chk({tag, ".id_inst"},  id_inst, inst);
        chk({tag, ".id_pc"},    id_pc, idpc);
        chk({tag, ".halted"},   {31'h0, halted}, {31'h0, h});
        chk({tag, ".fetch_err"},{31'h0, fetch_err}, {31'h0, f});
        chk({tag, ".misalign"}, {31'h0, misalign_err}, {31'h0, m});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = IA; mem[1] = IB; mem[2] = IC; mem[3] = ID;
        mem[255] = NOP;
        rst = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

        //          rst  rdy  rv   rpc          pc            v     inst  idpc   h     f     m
        // reset, boot bubble, straight-line run into the zero word
        tbl.push_back(mk(1'b1,1'b0,1'b0,32'h0,     32'h0,   1'b0, 32'h0, 32'h0, 1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b1,1'b1,1'b1,32'h8,     32'h0,   1'b0, 32'h0, 32'h0, 1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,32'h0,     32'h0,   1'b0, 32'h0, 32'h0, 1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,32'h0,     32'h4,   1'b1, IA,    32'h0, 1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,32'h0,     32'h8,   1'b1, IB,    32'h4, 1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,32'h0,     32'hC,   1'b1, IC,    32'h8, 1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,32'h0,     32'h10,  1'b1, ID,    32'hC, 1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,32'h0,     32'h10,  1'b0, ID,    32'hC, 1'b1,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,32'h0,     32'h10,  1'b0, ID,    32'hC, 1'b1,1'b0,1'b0));
        // leave HALT by redirect, then 3-cycle stall with id_pc = 4
        tbl.push_back(mk(1'b0,1'b1,1'b1,32'h0,     32'h0,   1'b0, ID,    32'hC, 1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,32'h0,     32'h4,   1'b1, IA,    32'h0, 1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,32'h0,     32'h8,   1'b1, IB,    32'h4, 1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,32'h0,     32'h8,   1'b1, IB,    32'h4, 1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,32'h0,     32'h8,   1'b1, IB,    32'h4, 1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,32'h0,     32'h8,   1'b1, IB,    32'h4, 1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,32'h0,     32'hC,   1'b1, IC,    32'h8, 1'b0,1'b0,1'b0));
        // redirect during stall
        tbl.push_back(mk(1'b0,1'b0,1'b0,32'h0,     32'hC,   1'b1, IC,    32'h8, 1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b1,32'hC,     32'hC,   1'b0, IC,    32'h8, 1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,32'h0,     32'h10,  1'b1, ID,    32'hC, 1'b0,1'b0,1'b0));
        // misaligned redirect beats halt-on-zero at pc 16
        tbl.push_back(mk(1'b0,1'b1,1'b1,32'h6,     32'h4,   1'b0, ID,    32'hC, 1'b0,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b1,1'b0,32'h0,     32'h8,   1'b1, IB,    32'h4, 1'b0,1'b0,1'b0));
        // out of range, then recovery
        tbl.push_back(mk(1'b0,1'b1,1'b1,32'h400,   32'h400, 1'b0, IB,    32'h4, 1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,32'h0,     32'h400, 1'b0, IB,    32'h4, 1'b1,1'b1,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,32'h0,     32'h400, 1'b0, IB,    32'h4, 1'b1,1'b1,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b1,32'h0,     32'h0,   1'b0, IB,    32'h4, 1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,32'h0,     32'h4,   1'b1, IA,    32'h0, 1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,32'h0,     32'h8,   1'b1, IB,    32'h4, 1'b0,1'b0,1'b0));
        // reset mid-run with a valid entry at pc 8
        tbl.push_back(mk(1'b1,1'b1,1'b0,32'h0,     32'h0,   1'b0, 32'h0, 32'h0, 1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,32'h0,     32'h0,   1'b0, 32'h0, 32'h0, 1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,32'h0,     32'h4,   1'b1, IA,    32'h0, 1'b0,1'b0,1'b0));

        @(negedge clk);
        foreach (tbl[i]) begin
            drive_step(tbl[i].rst, tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
            chk_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_v, tbl[i].e_inst,
                    tbl[i].e_idpc, tbl[i].e_halt, tbl[i].e_ferr, tbl[i].e_mis);
        end

        // Last in-range row is captured, then the range fault hits while decode stalls:
        // the entry must survive in HALT until consumed.
        drive_step(1'b0, 1'b1, 1'b1, 32'h3FC);
        chk_all("edge_redir", 32'h3FC, 1'b0, IA, 32'h0, 1'b0, 1'b0, 1'b0);
        drive_step(1'b0, 1'b1, 1'b0, 32'h0);
        chk_all("edge_last", 32'h400, 1'b1, NOP, 32'h3FC, 1'b0, 1'b0, 1'b0);
        drive_step(1'b0, 1'b0, 1'b0, 32'h0);
        chk_all("edge_oor_stall", 32'h400, 1'b1, NOP, 32'h3FC, 1'b1, 1'b1, 1'b0);
        drive_step(1'b0, 1'b0, 1'b0, 32'h0);
        chk_all("halt_hold", 32'h400, 1'b1, NOP, 32'h3FC, 1'b1, 1'b1, 1'b0);
        drive_step(1'b0, 1'b1, 1'b0, 32'h0);
        chk_all("halt_drain", 32'h400, 1'b0, NOP, 32'h3FC, 1'b1, 1'b1, 1'b0);

        // Reset ignores a concurrent redirect; a redirect in BOOT is applied.
        drive_step(1'b1, 1'b1, 1'b1, 32'h4);
        chk_all("rst_prio", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch_rst", perf_fetch_cnt, 32'h0);
        chk("perf_stall_rst", perf_stall_cnt, 32'h0);
`endif
        drive_step(1'b0, 1'b1, 1'b1, 32'h8);
        chk_all("boot_redir", 32'h8, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        drive_step(1'b0, 1'b0, 1'b0, 32'h0);
        chk_all("boot_fetch", 32'hC, 1'b1, IC, 32'h8, 1'b0, 1'b0, 1'b0);
        drive_step(1'b0, 1'b0, 1'b0, 32'h0);
        chk_all("boot_stall", 32'hC, 1'b1, IC, 32'h8, 1'b0, 1'b0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch", perf_fetch_cnt, 32'd1);
        chk("perf_stall", perf_stall_cnt, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the instruction memory (imem).
- Holds the program counter and drives the imem address every cycle.
- Captures the combinationally returned instruction word into an IF/ID pipeline register with a valid/ready handshake to decode.
- Handles branch/jump redirects, decode back-pressure, halt-on-empty-slot and fetch-range errors.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_DEPTH, 256, number of 32-bit imem rows; word index pc[31:2] >= IMEM_DEPTH is out of range.
- HALT_ON_ZERO, 1, if 1 a fetched all-zero word (unprogrammed imem row) stops fetch.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_pc  output  32  byte address to imem; always equals the internal PC.
- imem_inst  input  32  instruction from imem, combinational from imem_pc in the same cycle.
- id_valid  output  1  IF/ID register holds a valid instruction.
- id_ready  input  1  decode accepts the IF/ID contents this cycle.
- id_inst  output  32  registered instruction word.
- id_pc  output  32  PC of id_inst.
- redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc.
- redirect_pc  input  32  redirect target.
- halted  output  1  state is HALT.
- fetch_err  output  1  sticky out-of-range fetch flag.
- misalign_err  output  1  one-cycle pulse on a misaligned redirect.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. Reset has priority over all other inputs.
- Values while rst is high and in the cycle after:
  - pc = RESET_PC
  - id_valid = 0, id_inst = 0, id_pc = 0
  - halted = 0, fetch_err = 0, misalign_err = 0
  - state = BOOT
- States: BOOT, FETCH, HALT.
- BOOT: one bubble cycle with no capture, then FETCH. A redirect in BOOT is applied and the state moves to FETCH.
- FETCH, per cycle:
  - advance = !id_valid || id_ready.
  - If redirect_valid:
    - pc <= {redirect_pc[31:2], 2'b00}
    - id_valid <= 0 (flush; the word at the old pc is discarded)
    - misalign_err <= (redirect_pc[1:0] != 0)
    - Redirect beats stall and beats halt/error detection in the same cycle.
  - Else if pc[31:2] >= IMEM_DEPTH:
    - fetch_err <= 1, id_valid <= 0 once advance is true, state <= HALT.
  - Else if advance and HALT_ON_ZERO and imem_inst == 0:
    - id_valid <= 0, state <= HALT, pc held.
  - Else if advance:
    - id_inst <= imem_inst, id_pc <= pc, id_valid <= 1, pc <= pc + 4.
    - pc + 4 wraps modulo 2^32.
  - Else (stall): pc, id_inst, id_pc, id_valid all hold.
- HALT:
  - pc is frozen and no capture occurs.
  - An already-valid IF/ID entry stays until consumed by id_ready; id_valid <= 0 when it is consumed.
  - halted = 1 combinationally from state.
  - Only a redirect (-> FETCH, clears fetch_err) or reset leaves HALT.
- Latency: the instruction at address P appears on id_inst with id_valid = 1 on the first edge after pc == P, provided advance is true. Sustained throughput is 1 instruction/cycle with id_ready held at 1.
- id_inst and id_pc are stable while id_valid && !id_ready.
- misalign_err is high for exactly one cycle per misaligned redirect.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds output ports perf_fetch_cnt[31:0] and perf_stall_cnt[31:0].
  - perf_fetch_cnt increments on every capture (id_valid set with a new word).
  - perf_stall_cnt increments on every FETCH cycle with id_valid && !id_ready and no redirect.
  - Both counters clear on rst and wrap at 2^32.
- Undefined: the ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset then run: imem = {0x002081B3, 0x404182B3, 0x00532023, 0x00032383, 0...}, id_ready = 1 -> captures id_pc 0,4,8,12 in consecutive cycles; after the word at pc 16 (0) halted = 1 with pc = 16 and id_valid = 0.
- Stall: drop id_ready for 3 cycles while id_pc = 4 -> id_inst = 0x404182B3 and id_pc = 4 held; pc = 8 held; capture resumes at pc 8 on release.
- Redirect during stall: id_valid = 1, id_ready = 0, redirect_valid = 1, redirect_pc = 0x0C -> next cycle id_valid = 0, pc = 0x0C; following edge id_pc = 0x0C.
- Misaligned redirect: redirect_pc = 0x0000_0006 -> misalign_err one-cycle pulse, pc = 0x4.
- Out of range: redirect_pc = 0x400 with IMEM_DEPTH = 256 -> fetch_err = 1, halted = 1, no capture; redirect to 0x0 clears fetch_err and fetch resumes.
- Reset mid-run: assert rst while id_valid = 1 and pc = 8 -> next edge pc = RESET_PC, id_valid = 0, state BOOT; counters = 0 when FETCH_PERF_CNT_EN is defined.
